// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_cmd_rx : 8N1 UART command receiver with 'g'/'s' power-up authorization.
// Stop-bit checking and frm_err are enabled by `define UART_FRM_CHK_EN. Rev 1.0
// ---------------------------------------------------------------------------
module uart_cmd_rx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  // Counter expires on the cycle it reads zero, so loads are one short of the
  // interval; this puts each sample exactly BAUD_DIV/2 + k*BAUD_DIV after detect.
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

  logic rx_ff1, rx_s, rx_prev, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_s    <= rx_ff1;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  rx_state_t   rx_state, rx_state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n, rx_data_n;
  logic        rdy_n, byte_done, byte_done_n, expire;
`ifdef UART_FRM_CHK_EN
  logic        frm_q, frm_n, brk, brk_n;
`endif

  assign expire = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= IDLE;
      cnt       <= '0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rdy       <= 1'b0;
      byte_done <= 1'b0;
`ifdef UART_FRM_CHK_EN
      frm_q     <= 1'b0;
      brk       <= 1'b0;
`endif
    end else begin
      rx_state  <= rx_state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rdy       <= rdy_n;
      byte_done <= byte_done_n;
`ifdef UART_FRM_CHK_EN
      frm_q     <= frm_n;
      brk       <= brk_n;
`endif
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    cnt_n       = cnt;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rdy_n       = rdy & ~clr_rdy;
    byte_done_n = 1'b0;
`ifdef UART_FRM_CHK_EN
    frm_n       = 1'b0;
    brk_n       = brk;
`endif
    case (rx_state)
      IDLE: begin
        if (fall) begin
          rx_state_n = START;
          cnt_n      = HALF_M1;
          rdy_n      = 1'b0;
        end
      end
      START: begin
        if (!expire) begin
          cnt_n = cnt - CW'(1);
        end else if (rx_s) begin
          rx_state_n = IDLE;
        end else begin
          cnt_n      = FULL_M1;
          bit_cnt_n  = 4'd0;
          rx_state_n = DATA;
        end
      end
      DATA: begin
        if (!expire) begin
          cnt_n = cnt - CW'(1);
        end else begin
          shreg_n   = {rx_s, shreg[7:1]};
          cnt_n     = FULL_M1;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) rx_state_n = STOP;
        end
      end
      STOP: begin
`ifdef UART_FRM_CHK_EN
        if (brk) begin
          // Line held low past the stop bit: wait for it to return idle.
          if (rx_s) begin
            brk_n      = 1'b0;
            rx_state_n = IDLE;
          end
        end else if (!expire) begin
          cnt_n = cnt - CW'(1);
        end else if (rx_s) begin
          rx_data_n   = shreg;
          rdy_n       = 1'b1;
          byte_done_n = 1'b1;
          rx_state_n  = IDLE;
        end else begin
          frm_n = 1'b1;
          brk_n = 1'b1;
        end
`else
        if (!expire) begin
          cnt_n = cnt - CW'(1);
        end else begin
          rx_data_n   = shreg;
          rdy_n       = 1'b1;
          byte_done_n = 1'b1;
          rx_state_n  = IDLE;
        end
`endif
      end
      default: rx_state_n = IDLE;
    endcase
  end

`ifdef UART_FRM_CHK_EN
  assign frm_err = frm_q;
`else
  assign frm_err = 1'b0;
`endif

  auth_state_t auth, auth_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auth <= OFF;
    else        auth <= auth_n;
  end

  always_comb begin
    auth_n = auth;
    case (auth)
      OFF:  if (byte_done && rx_data == 8'h67) auth_n = PWR1;
      PWR1: if (byte_done && rx_data == 8'h73) auth_n = rider_off ? OFF : PWR2;
      PWR2: begin
        if (rider_off)                           auth_n = OFF;
        else if (byte_done && rx_data == 8'h67)  auth_n = PWR1;
      end
      default: auth_n = OFF;
    endcase
  end

  assign pwr_up = (auth != OFF);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// tb_uart_cmd_rx : directed self-checking bench for uart_cmd_rx at BAUD_DIV=16.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int BD = 16;
  localparam int LAT_LO = 154;
  localparam int LAT_HI = 158;

  logic       clk = 1'b0;
  logic       rst_n, RX, clr_rdy, rider_off;
  logic [7:0] rx_data;
  logic       rdy, frm_err, pwr_up;

  int total = 0, passed = 0, failed = 0;
  int rdy_cyc, pwr_cyc, frm_cyc, frm_cnt;

  uart_cmd_rx #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy), .rider_off(rider_off),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .pwr_up(pwr_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Drives one full frame starting at a negedge; records (in cycles from the
  // start-bit pin edge) when rdy rose, when pwr_up changed and frm_err activity.
  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    logic       prdy, ppwr;
    int         cyc;
    fr = {stop, b, 1'b0};
    prdy = rdy;
    ppwr = pwr_up;
    cyc = 0;
    rdy_cyc = 0; pwr_cyc = 0; frm_cyc = 0; frm_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (BD) begin
        @(negedge clk);
        cyc++;
        if (rdy && !prdy && rdy_cyc == 0) rdy_cyc = cyc;
        if (pwr_up != ppwr && pwr_cyc == 0) pwr_cyc = cyc;
        if (frm_err) begin
          frm_cnt++;
          if (frm_cyc == 0) frm_cyc = cyc;
        end
        prdy = rdy;
      end
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr_rdy = 1'b1;
    @(negedge clk) clr_rdy = 1'b0;
  endtask

  initial begin
    int seen_rdy, seen_frm;
    rst_n = 1'b0; RX = 1'b1; clr_rdy = 1'b0; rider_off = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rdy", rdy, 1'b0);
    chk("rst_frm_err", frm_err, 1'b0);
    chk("rst_pwr_up", pwr_up, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Power-up command 'g'
    send(8'h67, 1'b1);
    chk("g_rx_data", rx_data, 8'h67);
    chk("g_rdy", rdy, 1'b1);
    chk_rng("g_rdy_lat", rdy_cyc, LAT_LO, LAT_HI);
    chk("g_pwr_up", pwr_up, 1'b1);
    chk("g_pwr_lat", pwr_cyc, rdy_cyc + 1);
    chk("g_frm_cnt", frm_cnt, 0);
    pulse_clr();
    chk("clr_rdy", rdy, 1'b0);

    // 's' in PWR1 with rider on -> PWR2, then rider_off drops power
    send(8'h73, 1'b1);
    chk("s_rx_data", rx_data, 8'h73);
    chk("s_pwr2_pwr_up", pwr_up, 1'b1);
    rider_off = 1'b1;
    chk("roff_same_cyc", pwr_up, 1'b1);
    @(negedge clk);
    chk("roff_pwr_up", pwr_up, 1'b0);
    rider_off = 1'b0;

    // 's' in PWR1 with rider off -> OFF
    send(8'h67, 1'b1);
    chk("g2_pwr_up", pwr_up, 1'b1);
    rider_off = 1'b1;
    repeat (3) @(negedge clk);
    chk("pwr1_ignores_roff", pwr_up, 1'b1);
    send(8'h73, 1'b1);
    chk("s_roff_pwr_up", pwr_up, 1'b0);
    chk("s_roff_pwr_lat", pwr_cyc, rdy_cyc + 1);
    rider_off = 1'b0;

    // Short glitch: false start
    pulse_clr();
    seen_rdy = 0; seen_frm = 0;
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (rdy) seen_rdy++;
      if (frm_err) seen_frm++;
    end
    chk("glitch_rdy", seen_rdy, 0);
    chk("glitch_frm", seen_frm, 0);

    // Ignored byte in OFF
    send(8'hA5, 1'b1);
    chk("a5_rx_data", rx_data, 8'hA5);
    chk("a5_rdy", rdy, 1'b1);
    chk_rng("a5_rdy_lat", rdy_cyc, LAT_LO, LAT_HI);
    chk("a5_pwr_up", pwr_up, 1'b0);

    // Bad stop bit on 'g' while OFF
    pulse_clr();
    send(8'h67, 1'b0);
`ifdef UART_FRM_CHK_EN
    chk("fe_pulses", frm_cnt, 1);
    chk_rng("fe_lat", frm_cyc, LAT_LO, LAT_HI);
    chk("fe_rdy", rdy, 1'b0);
    chk("fe_rx_data", rx_data, 8'hA5);
    chk("fe_pwr_up", pwr_up, 1'b0);
`else
    chk("nofe_frm", frm_cnt, 0);
    chk("nofe_rdy", rdy, 1'b1);
    chk("nofe_rx_data", rx_data, 8'h67);
    chk("nofe_pwr_up", pwr_up, 1'b1);
`endif
    RX = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_fe_frm_err", frm_err, 1'b0);

    // Back-to-back frames
    pulse_clr();
    send(8'h55, 1'b1);
    chk("b2b1_rx_data", rx_data, 8'h55);
    chk_rng("b2b1_lat", rdy_cyc, LAT_LO, LAT_HI);
    send(8'hAA, 1'b1);
    chk("b2b2_rx_data", rx_data, 8'hAA);
    chk("b2b2_rdy", rdy, 1'b1);
    chk_rng("b2b2_lat", rdy_cyc, LAT_LO, LAT_HI);

    // Reset in the middle of a data bit
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (24) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_rdy", rdy, 1'b0);
    chk("mid_rst_frm_err", frm_err, 1'b0);
    chk("mid_rst_pwr_up", pwr_up, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send(8'h67, 1'b1);
    chk("after_rst_rx_data", rx_data, 8'h67);
    chk("after_rst_rdy", rdy, 1'b1);
    chk_rng("after_rst_lat", rdy_cyc, LAT_LO, LAT_HI);
    chk("after_rst_pwr_up", pwr_up, 1'b1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
